// File: rtl/simon_stream_sequencer.sv
// Streams 32-bit words into a 64-bit SIMON block cipher core and streams the
// 64-bit ciphertext back out as two 32-bit words, high word first.
module simon_stream_sequencer #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  core_plaintext,
    output logic [127:0] core_key,
    output logic         core_en,
    input  logic [63:0]  core_ciphertext,
    input  logic         core_done,
    output logic         busy,
    output logic         err_timeout,
    output logic [15:0]  blk_count
);

    localparam int unsigned CNT_W     = 6;
    localparam int unsigned CNT_LIMIT = (TIMEOUT > 64) ? 64 : ((TIMEOUT < 1) ? 1 : TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MASK = CNT_W'(2);

    typedef enum logic [2:0] {
        S_W0,
        S_W1,
        S_LAUNCH,
        S_OUT_HI,
        S_OUT_LO
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  launch_cnt;
    logic [31:0]       ct_lo;
    logic              done_ok;

    // Done seen in the first two launch cycles may be left over from the previous block.
    assign done_ok = core_done && (launch_cnt >= CNT_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_W0;
            launch_cnt     <= '0;
            ct_lo          <= '0;
            in_ready       <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            core_plaintext <= '0;
            core_key       <= '0;
            core_en        <= 1'b0;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
            blk_count      <= '0;
        end else begin
            case (state)
                S_W0: begin
                    in_ready <= 1'b1;
                    if (key_load) begin
                        core_key    <= key_in;
                        err_timeout <= 1'b0;
                    end
                    if (in_ready && in_valid) begin
                        core_plaintext[63:32] <= in_data;
                        busy                  <= 1'b1;
                        state                 <= S_W1;
                    end
                end
                S_W1: begin
                    if (in_valid) begin
                        core_plaintext[31:0] <= in_data;
                        core_en              <= 1'b1;
                        launch_cnt           <= '0;
                        in_ready             <= 1'b0;
                        state                <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (done_ok) begin
                        ct_lo     <= core_ciphertext[31:0];
                        out_data  <= core_ciphertext[63:32];
                        out_valid <= 1'b1;
                        core_en   <= 1'b0;
                        blk_count <= blk_count + 16'd1;
                        state     <= S_OUT_HI;
                    end else if (launch_cnt >= CNT_LAST) begin
                        // Abort: the block is dropped and the core released.
                        err_timeout <= 1'b1;
                        core_en     <= 1'b0;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= S_W0;
                    end else if (launch_cnt != CNT_MAX) begin
                        launch_cnt <= launch_cnt + CNT_W'(1);
                    end
                end
                S_OUT_HI: begin
                    if (out_ready) begin
                        out_data <= ct_lo;
                        state    <= S_OUT_LO;
                    end
                end
                S_OUT_LO: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_W0;
                    end
                end
                default: begin
                    state <= S_W0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_stream_sequencer.sv
// Scoreboard bench for simon_stream_sequencer with a behavioural cipher-core stand-in.
module tb_simon_stream_sequencer;

    localparam logic [127:0] KAT_KEY   = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [127:0] OTHER_KEY = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [63:0]  KAT_PT    = 64'h656b696c_20646e75;
    localparam logic [63:0]  KAT_CT    = 64'h44c8fc20_b9dfa07a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  core_plaintext;
    logic [127:0] core_key;
    logic         core_en;
    logic [63:0]  core_ciphertext = '0;
    logic         core_done = 1'b0;
    logic         busy;
    logic         err_timeout;
    logic [15:0]  blk_count;

    int vecs = 0;
    int errs = 0;
    logic [31:0] exp_q[$];

    // Core stand-in controls
    int lat = 3;
    bit stale_mode = 1'b0;
    bit never_done = 1'b0;
    logic         en_d = 1'b0;
    logic         run = 1'b0;
    int           m_cnt = 0;
    logic [63:0]  m_pt = '0;
    logic [127:0] m_key = '0;

    simon_stream_sequencer #(.TIMEOUT(63)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_plaintext(core_plaintext), .core_key(core_key), .core_en(core_en),
        .core_ciphertext(core_ciphertext), .core_done(core_done),
        .busy(busy), .err_timeout(err_timeout), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    // Reference vector for the known key/plaintext, a simple mixing function otherwise.
    function automatic logic [63:0] core_f(input logic [63:0] pt, input logic [127:0] k);
        if (pt == KAT_PT && k == KAT_KEY) return KAT_CT;
        return pt ^ k[127:64] ^ k[63:0] ^ 64'h01234567_89abcdef;
    endfunction

    always @(posedge clk) begin
        en_d <= core_en;
        if (!core_en) begin
            run <= 1'b0;
            if (!stale_mode) core_done <= 1'b0;
        end else if (!en_d) begin
            run   <= 1'b1;
            m_cnt <= lat;
            m_pt  <= core_plaintext;
            m_key <= core_key;
        end else if (run) begin
            core_done <= 1'b0;
            if (m_cnt == 0) begin
                run <= 1'b0;
                if (!never_done) begin
                    core_done       <= 1'b1;
                    core_ciphertext <= core_f(m_pt, m_key);
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Monitor: every accepted output beat is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_beat got=%h", out_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errs++;
                    $display("FAIL out_beat got=%h exp=%h", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] pt, input logic [63:0] ct, input bit expect_out);
        if (expect_out) begin
            exp_q.push_back(ct[63:32]);
            exp_q.push_back(ct[31:0]);
        end
        send_word(pt[63:32]);
        send_word(pt[31:0]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 128'(exp_q.size()), 0);
        exp_q.delete();
        step();
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_core_en"}, core_en, 0);
        chk({tag, "_core_pt"}, core_plaintext, 0);
        chk({tag, "_core_key"}, core_key, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_blk"}, blk_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int en_cycles;
        rst_n = 1'b0; key_in = '0; key_load = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        step();
        rst_n = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        step();

        // Known-answer block
        load_key(KAT_KEY);
        send_block(KAT_PT, KAT_CT, 1'b1);
        drain();
        @(negedge clk);
        chk("kat_blk", blk_count, 1);
        chk("kat_err", err_timeout, 0);
        chk("kat_key", core_key, KAT_KEY);
        chk("kat_pt", core_plaintext, KAT_PT);
        step();

        // Backpressure on the high word
        out_ready = 1'b0;
        send_block(KAT_PT, KAT_CT, 1'b1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 32'h44c8fc20);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_core_en", core_en, 0);
            @(negedge clk);
        end
        step();
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_blk", blk_count, 2);
        step();

        // Stale done level carried from one block into the next
        stale_mode = 1'b1;
        send_block(KAT_PT, KAT_CT, 1'b1);
        drain();
        send_block(64'h0, 64'h11335577_99bbddff, 1'b1);
        drain();
        @(negedge clk);
        chk("stale_blk", blk_count, 4);
        step();
        stale_mode = 1'b0;
        step();

        // Key load during launch is ignored
        send_block(KAT_PT, KAT_CT, 1'b1);
        load_key(OTHER_KEY);
        @(negedge clk);
        chk("lock_key", core_key, KAT_KEY);
        chk("lock_core_en", core_en, 1);
        step();
        drain();
        @(negedge clk);
        chk("lock_blk", blk_count, 5);
        step();

        // Core never finishes
        never_done = 1'b1;
        send_block(KAT_PT, KAT_CT, 1'b0);
        en_cycles = 0;
        n = 0;
        @(negedge clk);
        while (core_en && n < 300) begin
            en_cycles++;
            n++;
            @(negedge clk);
        end
        chk("to_cycles", en_cycles, 63);
        chk("to_err", err_timeout, 1);
        chk("to_core_en", core_en, 0);
        chk("to_busy", busy, 0);
        chk("to_in_ready", in_ready, 1);
        chk("to_out_valid", out_valid, 0);
        chk("to_blk", blk_count, 5);
        step();
        never_done = 1'b0;
        load_key(KAT_KEY);
        @(negedge clk);
        chk("to_clear_err", err_timeout, 0);
        step();

        // Reset in the middle of a launch
        send_block(KAT_PT, KAT_CT, 1'b0);
        repeat (2) step();
        rst_n = 1'b0;
        check_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        repeat (2) step();
        load_key(KAT_KEY);
        send_block(KAT_PT, KAT_CT, 1'b1);
        drain();
        @(negedge clk);
        chk("post_rst_blk", blk_count, 1);
        chk("post_rst_err", err_timeout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/simon_stream_sequencer.md
SIMON_STREAM_SEQUENCER -- requirements
Module: simon_stream_sequencer

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 63, the maximum number of cycles from core_en rising to core_done before the block is aborted.
REQ-002 The block SHALL have these ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_in  in  128  encryption key.
- key_load  in  1  one-cycle strobe that captures key_in.
- in_data  in  32  plaintext word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the block accepts in_data this cycle.
- out_data  out  32  ciphertext word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  the consumer accepts out_data this cycle.
- core_plaintext  out  64  drives the cipher core's plaintext input.
- core_key  out  128  drives the cipher core's key input.
- core_en  out  1  drives the cipher core's en input.
- core_ciphertext  in  64  the cipher core's ciphertext output.
- core_done  in  1  the cipher core's done output.
- busy  out  1  high in any state other than S_W0.
- err_timeout  out  1  sticky timeout flag.
- blk_count  out  16  number of completed blocks.

Function
REQ-003 The FSM SHALL have states S_W0, S_W1, S_LAUNCH, S_OUT_HI, S_OUT_LO, with one-hot or binary encoding free.
REQ-004 In S_W0, in_ready SHALL be 1. On in_valid, the block SHALL latch in_data into core_plaintext[63:32] and go to S_W1.
REQ-005 In S_W1, in_ready SHALL be 1. On in_valid, the block SHALL latch in_data into core_plaintext[31:0], set core_en to 1, clear the launch counter, and go to S_LAUNCH.
REQ-006 in_ready SHALL be 0 in S_LAUNCH, S_OUT_HI and S_OUT_LO.
REQ-007 In S_LAUNCH, core_en SHALL stay at 1, core_plaintext SHALL stay stable, and the 6-bit launch counter SHALL increment each cycle, saturating at 63.
REQ-008 In S_LAUNCH, core_done SHALL be honoured only when the launch counter is 2 or more. This masks a stale done level left over from the previous block.
REQ-009 On an honoured core_done, the block SHALL in the same edge:
- capture core_ciphertext into the output register;
- set core_en to 0;
- increment blk_count (16-bit, wraps 0xFFFF->0x0000);
- go to S_OUT_HI.
REQ-010 If the launch counter reaches TIMEOUT without an honoured core_done, the block SHALL set err_timeout to 1, set core_en to 0, discard the block, and go to S_W0.
REQ-011 In S_OUT_HI, out_valid SHALL be 1 and out_data SHALL be the captured ciphertext [63:32]. On out_ready the block SHALL go to S_OUT_LO.
REQ-012 In S_OUT_LO, out_valid SHALL be 1 and out_data SHALL be the captured ciphertext [31:0]. On out_ready the block SHALL go to S_W0.
REQ-013 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-014 core_en SHALL remain 0 for at least 2 cycles between blocks (S_OUT_HI and S_OUT_LO each last at least one cycle), so the core returns to idle before the next launch.
REQ-015 key_load SHALL update core_key only in S_W0 and SHALL be ignored in every other state. Once a block has launched, core_key therefore cannot change mid-encryption.
REQ-016 err_timeout SHALL be cleared only by reset or by an accepted key_load. If a timeout and an accepted key_load coincide, set SHALL win.
REQ-017 Minimum block latency SHALL be 2 input cycles + core latency + 2 output cycles. There is no internal buffering beyond one block.
REQ-018 A simultaneous in_valid and out_valid SHALL not be possible, because in_ready and out_valid are mutually exclusive.

Reset
REQ-019 With rst_n=0, asynchronously:
- state = S_W0;
- core_en = 0, core_plaintext = 0, core_key = 0, the output register = 0;
- out_valid = 0, in_ready deasserted until rst_n rises, then 1;
- busy = 0, err_timeout = 0, blk_count = 0, launch counter = 0.
REQ-020 Reset asserted mid-operation (any state) SHALL abort the block immediately, with no output beat and no blk_count change. core_en drops to 0 asynchronously.

Verification
REQ-021 Known-answer test, with the core attached:
- stimulus: key_load key_in=0x1b1a1918_13121110_0b0a0908_03020100, then in words 0x656b696c, 0x20646e75;
- response: out words 0x44c8fc20, then 0xb9dfa07a; blk_count=1; err_timeout=0.
REQ-022 Output backpressure: hold out_ready=0 for 10 cycles in S_OUT_HI -> out_valid stays 1, out_data stays 0x44c8fc20, in_ready stays 0, core_en stays 0.
REQ-023 Stale done: core model holds core_done=1 from the previous block -> the block does not complete before the launch counter reaches 2, and the ciphertext matches the second block.
REQ-024 Timeout: core model never asserts core_done -> after TIMEOUT=63 cycles in S_LAUNCH, err_timeout=1, core_en=0, state S_W0, no output beat, blk_count unchanged.
REQ-025 Key lock: key_load pulsed during S_LAUNCH with a different key -> core_key is unchanged and the block's ciphertext is still 0x44c8fc20_b9dfa07a.
REQ-026 Reset mid-run: rst_n=0 for one cycle during S_LAUNCH -> all outputs are at their reset values; the next full block produces the correct ciphertext with blk_count=1.
